// File: rtl/click_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Package     : click_decoder_pkg
// Description : Shared button-path definitions. Holds the default system
//               clock frequency, the IDLE/COLLECT burst-state encoding and a
//               millisecond-to-cycle conversion used by both the debouncer
//               and the click decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package click_decoder_pkg;

    localparam int SYSCLOCK_FREQ = 100_000_000;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } click_state_t;

    // Integer division is done first so the intermediate product stays well
    // inside 32 bits for realistic clock rates and windows.
    function automatic int ms_to_cycles(input int clk_freq, input int ms);
        return (clk_freq / 1000) * ms;
    endfunction

endpackage
`default_nettype wire

// File: rtl/click_decoder_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : Loadable down-counter. LOAD takes priority and sets the value;
//               otherwise a non-zero value decrements by one per cycle and
//               stops at zero.
// Ports       : CLK        - clock, rising edge
//               RESETN     - asynchronous active-low reset (value -> 0)
//               LOAD       - reload request
//               LOAD_VALUE - value taken on LOAD
//               EXPIRE     - value is 1 and no reload this cycle
//               ACTIVE     - value is non-zero
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VALUE,
    output logic             EXPIRE,
    output logic             ACTIVE
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (LOAD) begin
            value_d = LOAD_VALUE;
        end else if (value_q != '0) begin
            value_d = value_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign EXPIRE = (value_q == WIDTH'(1)) && !LOAD;
    assign ACTIVE = (value_q != '0);

endmodule
`default_nettype wire

// File: rtl/click_decoder.sv
`default_nettype none
// ============================================================================
// Module      : click_decoder
// Description : Groups debounced press pulses into bursts and reports the
//               number of clicks in each burst with a one-cycle VALID strobe.
//               A burst ends after GAP_MS without a press, or immediately
//               once MAX_CLICKS presses have been collected.
// Ports       : CLK    - system clock, rising edge
//               RESETN - asynchronous active-low reset
//               PRESS  - one-cycle pulse per debounced press
//               VALID  - one-cycle strobe, COUNT valid in this cycle
//               COUNT  - clicks in the completed burst, held until next VALID
//               BUSY   - high while a burst is being collected
// Revision    : 1.0 - initial release
// ============================================================================
module click_decoder
    import click_decoder_pkg::*;
#(
    parameter int CLK_FREQ   = SYSCLOCK_FREQ,
    parameter int GAP_MS     = 300,
    parameter int MAX_CLICKS = 3
) (
    input  logic                              CLK,
    input  logic                              RESETN,
    input  logic                              PRESS,
    output logic                              VALID,
    output logic [$clog2(MAX_CLICKS+1)-1:0]   COUNT,
    output logic                              BUSY
);

    localparam int GAP_CYCLES = ms_to_cycles(CLK_FREQ, GAP_MS);
    localparam int TW         = $clog2(GAP_CYCLES + 1);
    localparam int CW         = $clog2(MAX_CLICKS + 1);

    click_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, full_d;     // burst reached MAX_CLICKS, report next edge
    logic          valid_q, valid_d;
    logic [CW-1:0] count_q, count_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_value;
    logic          tmr_expire;
    logic          tmr_active;

    countdown_timer #(
        .WIDTH (TW)
    ) u_gap_timer (
        .CLK        (CLK),
        .RESETN     (RESETN),
        .LOAD       (tmr_load),
        .LOAD_VALUE (tmr_value),
        .EXPIRE     (tmr_expire),
        .ACTIVE     (tmr_active)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        full_d    = full_q;
        valid_d   = 1'b0;
        count_d   = count_q;
        tmr_load  = 1'b0;
        tmr_value = '0;

        if (full_q) begin
            // Burst hit the limit on the previous edge: report it and park
            // the timer so it cannot expire into a stale burst.
            valid_d   = 1'b1;
            count_d   = cnt_q;
            state_d   = ST_IDLE;
            cnt_d     = '0;
            full_d    = 1'b0;
            tmr_load  = 1'b1;
            tmr_value = '0;
        end else if (state_q == ST_COLLECT) begin
            if (PRESS) begin
                // A press always beats a coincident timer expiry.
                cnt_d     = cnt_q + 1'b1;
                tmr_load  = 1'b1;
                tmr_value = TW'(GAP_CYCLES);
                if (cnt_q == CW'(MAX_CLICKS - 1)) begin
                    full_d = 1'b1;
                end
            end else if (tmr_expire || !tmr_active) begin
                valid_d = 1'b1;
                count_d = cnt_q;
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end

        // New burst: from IDLE, or on the same edge a full burst is reported,
        // so a press coinciding with a report is never dropped.
        if (PRESS && ((state_q == ST_IDLE) || full_q)) begin
            cnt_d     = CW'(1);
            tmr_load  = 1'b1;
            tmr_value = TW'(GAP_CYCLES);
            if (MAX_CLICKS == 1) begin
                full_d  = 1'b1;
                state_d = ST_IDLE;
            end else begin
                full_d  = 1'b0;
                state_d = ST_COLLECT;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign VALID = valid_q;
    assign COUNT = count_q;
    assign BUSY  = (state_q == ST_COLLECT);

endmodule
`default_nettype wire
